// File: rtl/p15_register_file.sv
// AY-3-8910 compatible PSG bus interface and register file (R0-R13).
// Decodes BDIR/BC1, stores width-trimmed registers and exposes the static control fields.
module p15_register_file #(
   parameter logic [3:0] ADDR_HI = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bdir,
   input  logic        bc1,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [11:0] tone_period_a,
   output logic [11:0] tone_period_b,
   output logic [11:0] tone_period_c,
   output logic [4:0]  noise_period,
   output logic [2:0]  tone_disable,
   output logic [2:0]  noise_disable,
   output logic [4:0]  amplitude_a,
   output logic [4:0]  amplitude_b,
   output logic [4:0]  amplitude_c,
   output logic [15:0] envelope_period,
   output logic [3:0]  envelope_shape,
   output logic        envelope_restart
);

   localparam int          NUM_REGS   = 14;
   localparam logic [1:0]  MODE_IDLE  = 2'b00;
   localparam logic [1:0]  MODE_READ  = 2'b01;
   localparam logic [1:0]  MODE_WRITE = 2'b10;
   localparam logic [1:0]  MODE_LATCH = 2'b11;
   localparam logic [3:0]  REG_ENV_SHAPE = 4'd13;

   // Bits actually implemented in each register; everything else reads back as 0.
   function automatic logic [7:0] reg_mask(input logic [3:0] a);
      logic [7:0] m;
      case (a)
         4'd1, 4'd3, 4'd5, 4'd13:  m = 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10:  m = 8'h1F;
         4'd7:                     m = 8'h3F;
         4'd0, 4'd2, 4'd4,
         4'd11, 4'd12:             m = 8'hFF;
         default:                  m = 8'h00;
      endcase
      return m;
   endfunction

   logic [1:0] mode;
   logic       addr_valid;
   logic       wr_commit;
   logic [7:0] rd_data;

   logic [3:0] addr_q, addr_d;
   logic       sel_q, sel_d;
   logic       wr_prev_q, wr_prev_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];
   logic [7:0] data_out_q, data_out_d;
   logic       data_oe_q, data_oe_d;
   logic       env_restart_q, env_restart_d;

   assign mode       = {bdir, bc1};
   assign addr_valid = (addr_q < 4'(NUM_REGS));
   // Only the first cycle of a write phase commits; later cycles of the same phase are ignored.
   assign wr_commit  = (mode == MODE_WRITE) && !wr_prev_q && sel_q && addr_valid;

   always_comb begin
      rd_data = 8'h00;
      if (addr_valid) begin
         rd_data = regs_q[addr_q] & reg_mask(addr_q);
      end
   end

   always_comb begin
      addr_d        = addr_q;
      sel_d         = sel_q;
      regs_d        = regs_q;
      data_out_d    = data_out_q;
      data_oe_d     = 1'b0;
      env_restart_d = 1'b0;
      wr_prev_d     = (mode == MODE_WRITE);
      case (mode)
         MODE_LATCH: begin
            if (data_in[7:4] == ADDR_HI) begin
               addr_d = data_in[3:0];
               sel_d  = 1'b1;
            end else begin
               sel_d  = 1'b0;
            end
         end
         MODE_READ: begin
            if (sel_q) begin
               data_out_d = rd_data;
               data_oe_d  = 1'b1;
            end
         end
         MODE_WRITE: begin
            if (wr_commit) begin
               regs_d[addr_q] = data_in & reg_mask(addr_q);
               env_restart_d  = (addr_q == REG_ENV_SHAPE);
            end
         end
         MODE_IDLE: begin
            data_oe_d = 1'b0;
         end
         default: begin
            data_oe_d = 1'b0;
         end
      endcase
   end

   // Register stage: all state, outputs valid the cycle after the bus edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q        <= 4'd0;
         sel_q         <= 1'b1;
         wr_prev_q     <= 1'b0;
         data_out_q    <= 8'h00;
         data_oe_q     <= 1'b0;
         env_restart_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         addr_q        <= addr_d;
         sel_q         <= sel_d;
         wr_prev_q     <= wr_prev_d;
         data_out_q    <= data_out_d;
         data_oe_q     <= data_oe_d;
         env_restart_q <= env_restart_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign data_out         = data_out_q;
   assign data_oe          = data_oe_q;
   assign tone_period_a    = {regs_q[1][3:0], regs_q[0]};
   assign tone_period_b    = {regs_q[3][3:0], regs_q[2]};
   assign tone_period_c    = {regs_q[5][3:0], regs_q[4]};
   assign noise_period     = regs_q[6][4:0];
   assign tone_disable     = regs_q[7][2:0];
   assign noise_disable    = regs_q[7][5:3];
   assign amplitude_a      = regs_q[8][4:0];
   assign amplitude_b      = regs_q[9][4:0];
   assign amplitude_c      = regs_q[10][4:0];
   assign envelope_period  = {regs_q[12], regs_q[11]};
   assign envelope_shape   = regs_q[13][3:0];
   assign envelope_restart = env_restart_q;

endmodule

// File: tb/tb_p15_register_file.sv
// Bench for p15_register_file: directed scenarios plus random bus traffic,
// every cycle compared against a register-array model of the PSG bus rules.
module tb_p15_register_file;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bdir = 1'b0;
   logic        bc1 = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [11:0] tone_period_a, tone_period_b, tone_period_c;
   logic [4:0]  noise_period;
   logic [2:0]  tone_disable, noise_disable;
   logic [4:0]  amplitude_a, amplitude_b, amplitude_c;
   logic [15:0] envelope_period;
   logic [3:0]  envelope_shape;
   logic        envelope_restart;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_reg [14];
   int m_addr, m_dout;
   bit m_sel, m_prev_wr, m_oe, m_rs;
   int wid [14] = '{8, 4, 8, 4, 8, 4, 5, 6, 5, 5, 5, 8, 8, 4};

   p15_register_file #(.ADDR_HI(4'h0)) dut (
      .clk(clk), .rst_n(rst_n), .bdir(bdir), .bc1(bc1), .data_in(data_in),
      .data_out(data_out), .data_oe(data_oe),
      .tone_period_a(tone_period_a), .tone_period_b(tone_period_b), .tone_period_c(tone_period_c),
      .noise_period(noise_period), .tone_disable(tone_disable), .noise_disable(noise_disable),
      .amplitude_a(amplitude_a), .amplitude_b(amplitude_b), .amplitude_c(amplitude_c),
      .envelope_period(envelope_period), .envelope_shape(envelope_shape),
      .envelope_restart(envelope_restart)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input int md, input int v);
      if (!r) begin
         for (int i = 0; i < 14; i++) m_reg[i] = 0;
         m_addr = 0; m_sel = 1; m_prev_wr = 0; m_dout = 0; m_oe = 0; m_rs = 0;
      end else begin
         m_oe = 0;
         m_rs = 0;
         if (md == 3) begin
            if (v / 16 == 0) begin m_addr = v % 16; m_sel = 1; end
            else m_sel = 0;
         end else if (md == 1) begin
            if (m_sel) begin
               m_dout = (m_addr < 14) ? m_reg[m_addr] : 0;
               m_oe = 1;
            end
         end else if (md == 2) begin
            if (!m_prev_wr && m_sel && m_addr < 14) begin
               m_reg[m_addr] = v % (1 << wid[m_addr]);
               if (m_addr == 13) m_rs = 1;
            end
         end
         m_prev_wr = (md == 2);
      end
   endtask

   task automatic check_all();
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("data_oe", 32'(data_oe), 32'(m_oe));
      chk("tone_a", 32'(tone_period_a), 32'(m_reg[1] * 256 + m_reg[0]));
      chk("tone_b", 32'(tone_period_b), 32'(m_reg[3] * 256 + m_reg[2]));
      chk("tone_c", 32'(tone_period_c), 32'(m_reg[5] * 256 + m_reg[4]));
      chk("noise_period", 32'(noise_period), 32'(m_reg[6]));
      chk("tone_disable", 32'(tone_disable), 32'(m_reg[7] % 8));
      chk("noise_disable", 32'(noise_disable), 32'(m_reg[7] / 8));
      chk("amp_a", 32'(amplitude_a), 32'(m_reg[8]));
      chk("amp_b", 32'(amplitude_b), 32'(m_reg[9]));
      chk("amp_c", 32'(amplitude_c), 32'(m_reg[10]));
      chk("env_period", 32'(envelope_period), 32'(m_reg[12] * 256 + m_reg[11]));
      chk("env_shape", 32'(envelope_shape), 32'(m_reg[13]));
      chk("env_restart", 32'(envelope_restart), 32'(m_rs));
   endtask

   // One clock: drive inputs, advance the model across the edge, compare just after it.
   task automatic cyc(input bit r, input int md, input int v);
      rst_n   = r;
      bdir    = md[1];
      bc1     = md[0];
      data_in = 8'(v);
      @(posedge clk);
      model_step(r, md, v);
      #1;
      check_all();
   endtask

   task automatic latch(input int v);  cyc(1, 3, v); endtask
   task automatic idle();              cyc(1, 0, 0); endtask
   task automatic rd();                cyc(1, 1, 0); endtask
   task automatic wr(input int v);     cyc(1, 2, v); endtask

   initial begin
      int md, v;
      for (int i = 0; i < 14; i++) m_reg[i] = 0;
      m_addr = 0; m_sel = 1; m_prev_wr = 0; m_dout = 0; m_oe = 0; m_rs = 0;
      #1;
      cyc(0, 0, 0);
      cyc(0, 2, 8'h77);
      chk("rst_noise", 32'(noise_period), 32'h0);
      chk("rst_oe", 32'(data_oe), 32'h0);
      idle();

      // Noise period write with held write phase
      latch(8'h06);
      wr(8'hFF);
      chk("t1_noise", 32'(noise_period), 32'h1F);
      chk("t1_tone_a", 32'(tone_period_a), 32'h0);
      wr(8'h00);
      wr(8'h00);
      chk("t1_noise_hold", 32'(noise_period), 32'h1F);
      chk("t1_restart", 32'(envelope_restart), 32'h0);
      idle();

      // Envelope restart pulse: one per write phase
      latch(8'h0D);
      wr(8'h0A);
      chk("t2_shape", 32'(envelope_shape), 32'hA);
      chk("t2_pulse", 32'(envelope_restart), 32'h1);
      for (int i = 0; i < 4; i++) begin
         wr(8'h0A);
         chk("t2_nopulse", 32'(envelope_restart), 32'h0);
      end
      idle();
      wr(8'h0A);
      chk("t2_pulse2", 32'(envelope_restart), 32'h1);
      idle();

      // Tone period A and read-back of R1
      latch(8'h01); wr(8'hF5); idle();
      latch(8'h00); wr(8'h34); idle();
      chk("t3_tone_a", 32'(tone_period_a), 32'h534);
      latch(8'h01);
      rd();
      chk("t3_rd_data", 32'(data_out), 32'h05);
      chk("t3_rd_oe", 32'(data_oe), 32'h1);
      idle();
      chk("t3_oe_drop", 32'(data_oe), 32'h0);

      // Chip-select mismatch
      latch(8'h26); wr(8'h11); idle();
      chk("t4_noise_keep", 32'(noise_period), 32'h1F);
      rd();
      chk("t4_rd_oe", 32'(data_oe), 32'h0);
      latch(8'h06); wr(8'h11); idle();
      chk("t4_noise", 32'(noise_period), 32'h11);

      // Mixer, amplitude and unimplemented I/O port
      latch(8'h07); wr(8'hFF); idle();
      latch(8'h08); wr(8'hFF); idle();
      latch(8'h0E); wr(8'hAA); idle();
      chk("t5_tone_dis", 32'(tone_disable), 32'h7);
      chk("t5_noise_dis", 32'(noise_disable), 32'h7);
      chk("t5_amp_a", 32'(amplitude_a), 32'h1F);
      latch(8'h07); rd();
      chk("t5_rd_r7", 32'(data_out), 32'h3F);
      latch(8'h0E); rd();
      chk("t5_rd_r14", 32'(data_out), 32'h00);
      chk("t5_rd_r14_oe", 32'(data_oe), 32'h1);
      idle();

      // Program everything, then reset in the middle of a write phase
      for (int a = 0; a < 14; a++) begin
         latch(a);
         wr($urandom_range(1, 255));
         idle();
      end
      latch(8'h03);
      wr(8'h09);
      cyc(0, 2, 8'h09);
      cyc(0, 2, 8'h09);
      chk("t6_tone_a", 32'(tone_period_a), 32'h0);
      chk("t6_env", 32'(envelope_period), 32'h0);
      chk("t6_oe", 32'(data_oe), 32'h0);
      wr(8'h5A);
      chk("t6_first_r0", 32'(tone_period_a), 32'h05A);
      chk("t6_tone_b", 32'(tone_period_b), 32'h0);
      idle();

      // Random bus traffic
      for (int n = 0; n < 600; n++) begin
         md = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 255));
         else v = int'($urandom_range(0, 15));
         if ($urandom_range(0, 79) == 0) cyc(0, md, v);
         else cyc(1, md, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
